// File: rtl/coef_loader.sv
// Byte-serial coefficient loader: shadow bank, commit, core launch.
// Ports: in_* byte stream, coef bank out, start_calc / core_busy
// handshake, chk_err pulse. COEF_LOADER_CHECKSUM_EN adds a trailing
// XOR checksum byte per frame.
module coef_loader #(
  parameter int NUM_COEF = 4,
  parameter int COEF_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_COEF*COEF_W-1:0] coef,
  output logic                       start_calc,
  input  logic                       core_busy,
  output logic                       chk_err
);

  localparam int BYTES = COEF_W / 8;
  localparam int TOTAL = NUM_COEF * BYTES;
  localparam int FW    = NUM_COEF * COEF_W;
  localparam int CW    = $clog2(TOTAL + 2);
`ifdef COEF_LOADER_CHECKSUM_EN
  localparam int LAST  = TOTAL;
`else
  localparam int LAST  = TOTAL - 1;
`endif

  typedef enum logic {
    LOAD,
    FULL
  } load_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    RUN
  } run_t;

  load_t          ls, ls_n;
  run_t           rs, rs_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [FW-1:0]  shadow, coef_q;
  logic           chk_q, drop;
  logic           accept, last, commit;
`ifdef COEF_LOADER_CHECKSUM_EN
  logic [7:0]     xsum, xsum_n;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(LAST));
  assign commit = (ls == FULL) && (rs == IDLE) && !core_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ls     <= LOAD;
      rs     <= IDLE;
      cnt    <= '0;
      chk_q  <= 1'b0;
    end else begin
      ls     <= ls_n;
      rs     <= rs_n;
      cnt    <= cnt_n;
      chk_q  <= drop;
    end
  end

`ifdef COEF_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) xsum <= '0;
    else     xsum <= xsum_n;
  end
`endif

  // The checksum byte sits at index TOTAL, past the
  // loop range, so it never lands in the shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      coef_q <= '0;
    end else begin
      if (drop) begin
        shadow <= '0;
      end else begin
        for (int i = 0; i < TOTAL; i++) begin
          if (accept && cnt == CW'(i))
            shadow[i*8 +: 8] <= in_data;
        end
      end
      if (commit) coef_q <= shadow;
    end
  end

  always_comb begin
    ls_n  = ls;
    cnt_n = cnt;
    drop  = 1'b0;
`ifdef COEF_LOADER_CHECKSUM_EN
    xsum_n = xsum;
`endif
    unique case (ls)
      LOAD: begin
        if (accept) begin
          if (last) begin
            cnt_n = '0;
`ifdef COEF_LOADER_CHECKSUM_EN
            xsum_n = '0;
            if (in_data == xsum) ls_n = FULL;
            else                 drop = 1'b1;
`else
            ls_n = FULL;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
`ifdef COEF_LOADER_CHECKSUM_EN
            xsum_n = xsum ^ in_data;
`endif
          end
        end
      end
      FULL: begin
        if (commit) ls_n = LOAD;
      end
    endcase
  end

  always_comb begin
    rs_n = rs;
    unique case (rs)
      IDLE:     if (commit)     rs_n = START;
      START:                    rs_n = WAIT_ACK;
      WAIT_ACK: if (core_busy)  rs_n = RUN;
      RUN:      if (!core_busy) rs_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (ls == LOAD);
    start_calc = (rs == START);
    chk_err    = chk_q;
    coef       = coef_q;
  end

endmodule

// File: doc/coef_loader.md
COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 SHALL have parameter NUM_COEF, default 4, number of coefficients per frame (1..16).
REQ-002 SHALL have parameter COEF_W, default 32, coefficient width in bits (multiple of 8, 8..32); BYTES = COEF_W/8.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  8  byte-serial coefficient stream.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 coef  output  NUM_COEF*COEF_W  committed coefficients, coef i at bits [i*COEF_W +: COEF_W].
REQ-010 start_calc  output  1  one-cycle launch pulse to the core.
REQ-011 core_busy  input  1  core computing.
REQ-012 chk_err  output  1  one-cycle pulse, frame checksum mismatch.

Function
REQ-013 Byte accepted iff in_valid && in_ready on a rising edge.
REQ-014 Frame = NUM_COEF*BYTES payload bytes, coef 0 first, each coefficient least-significant byte first; bytes written into a shadow register bank, never directly into coef.
REQ-015 Load FSM states: LOAD (in_ready=1, counting bytes), FULL (in_ready=0, shadow complete).
REQ-016 LOAD -> FULL on acceptance of the last frame byte; FULL -> LOAD in the commit cycle.
REQ-017 Launch FSM states: IDLE, START, WAIT_ACK, RUN.
REQ-018 Commit occurs in a cycle where launch FSM is IDLE, load FSM is FULL and core_busy=0: shadow copied to coef, launch FSM -> START.
REQ-019 START: start_calc=1 for exactly one cycle (asserted the cycle after commit), then -> WAIT_ACK.
REQ-020 WAIT_ACK -> RUN when core_busy=1; RUN -> IDLE when core_busy=0.
REQ-021 Loading of the next frame is permitted from the cycle after commit, including during START/WAIT_ACK/RUN; coef stays stable until the next commit.
REQ-022 core_busy=1 while FULL and IDLE: commit deferred, shadow and coef held, in_ready=0 (back-pressure).
REQ-023 in_valid with in_ready=0: byte ignored, no state change.
REQ-024 start_calc never asserted without a preceding commit; at most one start_calc per frame.

Reset
REQ-025 rst=1 in any cycle SHALL force: load FSM LOAD, byte counter 0, shadow 0, coef 0, launch FSM IDLE, start_calc 0, chk_err 0, in_ready 1 (from the first cycle after rst deasserts).
REQ-026 Reset mid-frame discards all partial bytes; the next accepted byte is byte 0 of coef 0.
REQ-027 Reset during RUN returns to IDLE without waiting for core_busy to fall.

Configuration
REQ-028 Macro COEF_LOADER_CHECKSUM_EN, when defined: frame carries one trailing checksum byte = XOR of all payload bytes; FULL entered only on acceptance of a matching checksum byte.
REQ-029 With COEF_LOADER_CHECKSUM_EN on a mismatch: chk_err=1 for one cycle the cycle after the checksum byte, shadow discarded (no commit, no start_calc), load FSM stays LOAD with counter 0.
REQ-030 Without COEF_LOADER_CHECKSUM_EN: no checksum byte, FULL entered on last payload byte, chk_err tied 0.

Verification
REQ-031 NUM_COEF=2, COEF_W=16, core_busy=0, bytes 34 12 78 56 -> coef=0x5678_1234, start_calc single pulse the cycle after commit.
REQ-032 Same frame with core_busy=1 throughout load, dropped 10 cycles later -> in_ready=0 while FULL, commit and start_calc only after core_busy falls.
REQ-033 Second frame AA BB CC DD streamed during RUN -> coef remains 0x5678_1234 until RUN->IDLE, then 0xDDCC_BBAA and second start_calc.
REQ-034 COEF_LOADER_CHECKSUM_EN, payload 34 12 78 56 with checksum 00 (correct = 08) -> chk_err one pulse, coef unchanged, no start_calc; resend with 08 -> commit.
REQ-035 rst pulsed after 3 of 4 bytes, then 01 00 02 00 -> coef=0x0002_0001, no residue from aborted frame.
